// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles framed bytes into 32-bit words, writes them to
// instruction memory and holds the CPU in reset until a checksummed frame has loaded.
module imem_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH_C = 32'd1 << ADDR_W;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                in_ready_r;
  logic                imem_we_r;
  logic [ADDR_W-1:0]   imem_waddr_r;
  logic [31:0]         imem_wdata_r;
  logic                cpu_hold_r;
  logic                load_done_r;
  logic                load_err_r;
  logic [7:0]          n_r;
  logic [7:0]          words_r;
  logic [1:0]          idx_r;
  logic [7:0]          chk_r;
  logic                xfer_s;
  logic                we_nxt_s;
  logic                count_bad_s;
  logic                last_word_s;

  // Running frame checksum: XOR of every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  assign xfer_s      = in_valid & in_ready_r;
  assign count_bad_s = (in_data == 8'd0) || ({24'd0, in_data} > DEPTH_C);
  assign last_word_s = (words_r == (n_r - 8'd1));

  assign in_ready   = in_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_waddr = imem_waddr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign load_done  = load_done_r;
  assign load_err   = load_err_r;

  // Next-state and write-strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    we_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s && (in_data == SYNC)) begin
          state_nxt_s = COUNT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COUNT: begin
        if (xfer_s) begin
          if (count_bad_s) begin
            state_nxt_s = ERROR;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = COUNT;
        end
      end
      DATA: begin
        // The strobe cycle blocks input, so a byte can never arrive alongside it.
        if (imem_we_r) begin
          if (last_word_s) begin
            state_nxt_s = CHECK;
          end else begin
            state_nxt_s = DATA;
          end
        end else if (xfer_s && (idx_r == 2'd3)) begin
          we_nxt_s    = 1'b1;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = DATA;
        end
      end
      CHECK: begin
        if (xfer_s) begin
          if (in_data == chk_r) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ERROR;
          end
        end else begin
          state_nxt_s = CHECK;
        end
      end
      DONE, ERROR: begin
        if (xfer_s && (in_data == SYNC)) begin
          state_nxt_s = COUNT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Status outputs follow the next state so cpu_hold and load_done switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      imem_we_r   <= 1'b0;
      cpu_hold_r  <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      in_ready_r  <= ~we_nxt_s;
      imem_we_r   <= we_nxt_s;
      cpu_hold_r  <= (state_nxt_s != DONE);
      load_done_r <= (state_nxt_s == DONE);
      load_err_r  <= (state_nxt_s == ERROR);
    end
  end

  // Frame datapath: word assembly, checksum, word count and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_waddr_r <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'd0;
      n_r          <= 8'd0;
      words_r      <= 8'd0;
      idx_r        <= 2'd0;
      chk_r        <= 8'd0;
    end else if ((state_r == COUNT) && (state_nxt_s == DATA)) begin
      n_r          <= in_data;
      words_r      <= 8'd0;
      idx_r        <= 2'd0;
      chk_r        <= 8'd0;
      imem_waddr_r <= {ADDR_W{1'b0}};
    end else if ((state_r == DATA) && xfer_s) begin
      imem_wdata_r[{idx_r, 3'b000} +: 8] <= in_data;
      chk_r <= chk_update(chk_r, in_data);
      idx_r <= idx_r + 2'd1;
    end else if ((state_r == DATA) && imem_we_r) begin
      // Address steps after the strobe; held on the last word so it never wraps.
      words_r <= words_r + 8'd1;
      if (!last_word_s) begin
        imem_waddr_r <= imem_waddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        imem_waddr_r <= imem_waddr_r;
      end
    end else begin
      imem_waddr_r <= imem_waddr_r;
      chk_r        <= chk_r;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/count errors, backpressure and
// mid-frame reset, on a default instance and a 4-word (ADDR_W=2) instance.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data, in_data2;
  logic        in_valid, in_valid2;
  logic        in_ready, in_ready2;
  logic        imem_we, imem_we2;
  logic [7:0]  imem_waddr;
  logic [1:0]  imem_waddr2;
  logic [31:0] imem_wdata, imem_wdata2;
  logic        cpu_hold, cpu_hold2;
  logic        load_done, load_done2;
  logic        load_err, load_err2;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr2_cnt  = 0;
  logic [7:0]  fr[$];
  int          base;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  imem_loader #(.ADDR_W(2), .SYNC(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .imem_we(imem_we2), .imem_waddr(imem_waddr2), .imem_wdata(imem_wdata2),
    .cpu_hold(cpu_hold2), .load_done(load_done2), .load_err(load_err2)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Write monitor: strobe is sampled mid-cycle; input must be blocked while it is high.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(32'(imem_waddr));
      wr_data_q.push_back(imem_wdata);
      check_val("rdy_during_we", 32'(in_ready), 32'd0);
    end
    if (imem_we2 === 1'b1) wr2_cnt++;
  end

  task automatic send_byte(input int sel, input logic [7:0] b);
    int guard;
    guard = 0;
    if (sel == 0) begin in_data = b; in_valid = 1'b1; end
    else begin in_data2 = b; in_valid2 = 1'b1; end
    while ((((sel == 0) ? in_ready : in_ready2) !== 1'b1) && (guard < 50)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_val("ready_timeout", 32'((sel == 0) ? in_ready : in_ready2), 32'd1);
    @(negedge clk);
  endtask

  task automatic drop_valid(input int sel);
    if (sel == 0) in_valid = 1'b0;
    else in_valid2 = 1'b0;
  endtask

  // Sends fr[first..]; after each 4th payload byte the strobe must already be high.
  task automatic send_frame(input int sel, input int gap_max, input int first);
    int nwords;
    int g;
    nwords = (fr.size() > 1) ? int'(fr[1]) : 0;
    for (int k = first; k < fr.size(); k++) begin
      send_byte(sel, fr[k]);
      if ((k >= 2) && (k < 2 + 4 * nwords) && (((k - 2) % 4) == 3)) begin
        check_val("we_latency", 32'((sel == 0) ? imem_we : imem_we2), 32'd1);
        check_val("rdy_low_in_we", 32'((sel == 0) ? in_ready : in_ready2), 32'd0);
      end
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          drop_valid(sel);
          repeat (g) @(negedge clk);
        end
      end
    end
    drop_valid(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_data = 8'd0; in_data2 = 8'd0;
    repeat (3) @(negedge clk);

    // T1 reset values and in_ready after release
    check_val("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_val("rst_we", 32'(imem_we), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd0);
    check_val("rst_done", 32'(load_done), 32'd0);
    check_val("rst_err", 32'(load_err), 32'd0);
    check_val("rst_waddr", 32'(imem_waddr), 32'd0);
    check_val("rst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    check_val("rel_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check_val("rel_ready_high", 32'(in_ready), 32'd1);
    check_val("rel_ready2_high", 32'(in_ready2), 32'd1);

    // T2 good two-word load
    base = wr_addr_q.size();
    fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'hF1, 8'h93, 8'h00, 8'h20, 8'h00, 8'h41};
    send_frame(0, 0, 0);
    check_val("t2_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    if (wr_addr_q.size() >= base + 2) begin
      check_val("t2_a0", wr_addr_q[base], 32'd0);
      check_val("t2_d0", wr_data_q[base], 32'hF1100013);
      check_val("t2_a1", wr_addr_q[base+1], 32'd1);
      check_val("t2_d1", wr_data_q[base+1], 32'h00200093);
    end
    check_val("t2_done", 32'(load_done), 32'd1);
    check_val("t2_hold", 32'(cpu_hold), 32'd0);
    check_val("t2_err", 32'(load_err), 32'd0);

    // T3 bad checksum: words still written, error raised
    base = wr_addr_q.size();
    fr[10] = 8'h40;
    send_frame(0, 0, 0);
    check_val("t3_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    check_val("t3_err", 32'(load_err), 32'd1);
    check_val("t3_hold", 32'(cpu_hold), 32'd1);
    check_val("t3_done", 32'(load_done), 32'd0);

    // T4 N=0 is illegal
    base = wr_addr_q.size();
    fr = '{8'hA5, 8'h00};
    send_frame(0, 0, 0);
    repeat (2) @(negedge clk);
    check_val("t4_n0_err", 32'(load_err), 32'd1);
    check_val("t4_n0_nwr", 32'(wr_addr_q.size() - base), 32'd0);

    // T3 resend good frame from ERROR
    fr = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'hF1, 8'h93, 8'h00, 8'h20, 8'h00, 8'h41};
    send_byte(0, fr[0]);
    check_val("t3_sync_clr_err", 32'(load_err), 32'd0);
    send_frame(0, 0, 1);
    check_val("t3_re_done", 32'(load_done), 32'd1);
    check_val("t3_re_err", 32'(load_err), 32'd0);
    check_val("t3_re_hold", 32'(cpu_hold), 32'd0);

    // T4 ADDR_W=2: N=4 fills memory exactly, N=5 rejected
    fr = '{8'hA5, 8'h04};
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h00);
    send_frame(1, 0, 0);
    check_val("t4_n4_done", 32'(load_done2), 32'd1);
    check_val("t4_n4_nwr", 32'(wr2_cnt), 32'd4);
    check_val("t4_n4_waddr", 32'(imem_waddr2), 32'd3);
    fr = '{8'hA5, 8'h05};
    send_frame(1, 0, 0);
    repeat (2) @(negedge clk);
    check_val("t4_n5_err", 32'(load_err2), 32'd1);
    check_val("t4_n5_done", 32'(load_done2), 32'd0);
    check_val("t4_n5_nwr", 32'(wr2_cnt), 32'd4);

    // T5 reload after DONE with gaps and SYNC-valued payload bytes
    base = wr_addr_q.size();
    fr = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA5, 8'h04, 8'hA1};
    send_byte(0, fr[0]);
    check_val("t5_hold_reload", 32'(cpu_hold), 32'd1);
    check_val("t5_done_reload", 32'(load_done), 32'd0);
    send_frame(0, 2, 1);
    check_val("t5_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    if (wr_addr_q.size() >= base + 2) begin
      check_val("t5_a0", wr_addr_q[base], 32'd0);
      check_val("t5_d0", wr_data_q[base], 32'h0100A5A5);
      check_val("t5_a1", wr_addr_q[base+1], 32'd1);
      check_val("t5_d1", wr_data_q[base+1], 32'h04A50302);
    end
    check_val("t5_done", 32'(load_done), 32'd1);

    // T6 async reset after two payload bytes, then fresh load
    base = wr_addr_q.size();
    send_byte(0, 8'hA5);
    send_byte(0, 8'h02);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6_hold", 32'(cpu_hold), 32'd1);
    check_val("t6_ready", 32'(in_ready), 32'd0);
    check_val("t6_we", 32'(imem_we), 32'd0);
    check_val("t6_done", 32'(load_done), 32'd0);
    check_val("t6_err", 32'(load_err), 32'd0);
    check_val("t6_waddr", 32'(imem_waddr), 32'd0);
    check_val("t6_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_nwr", 32'(wr_addr_q.size() - base), 32'd0);
    check_val("t6_ready_back", 32'(in_ready), 32'd1);
    fr = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_frame(0, 1, 0);
    check_val("t6_re_nwr", 32'(wr_addr_q.size() - base), 32'd1);
    if (wr_addr_q.size() >= base + 1) begin
      check_val("t6_re_a0", wr_addr_q[base], 32'd0);
      check_val("t6_re_d0", wr_data_q[base], 32'h12345678);
    end
    check_val("t6_re_done", 32'(load_done), 32'd1);
    check_val("t6_re_hold", 32'(cpu_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
